// File: rtl/temp_conversion_sequencer.sv
// Periodic ramp-measurement sequencer: triggers a down-ramp, hands the measured time to the
// time-to-temperature converter, and publishes the average of 2^AVG_LOG2 good conversions.
module temp_conversion_sequencer #(
  parameter int PERIOD_CYCLES  = 1_000_000,
  parameter int TIMEOUT_CYCLES = 1_048_575,
  parameter int AVG_LOG2       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        ramp_start,
  input  logic        ramp_done,
  input  logic [19:0] ramp_time,
  output logic        conv_start,
  output logic [19:0] conv_time,
  input  logic        conv_eoc,
  input  logic [9:0]  conv_temp,
  input  logic        conv_oor,
  output logic [9:0]  temp_avg,
  output logic        temp_valid,
  output logic        oor_flag,
  output logic        timeout_flag,
  output logic        busy
);

  localparam int ACC_W = 10 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [31:0]      PERIOD_LAST = 32'(PERIOD_CYCLES - 1);
  localparam logic [31:0]      TMO_LAST    = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RAMP, S_CONVERT, S_PUBLISH} state_t;

  state_t           state, state_nx;
  logic [31:0]      tmr, tmr_nx;
  logic [ACC_W-1:0] acc, acc_nx, acc_sum;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             ramp_start_nx, conv_start_nx, temp_valid_nx, oor_nx, tmo_nx;
  logic [19:0]      conv_time_nx;
  logic [9:0]       temp_avg_nx;

  assign acc_sum = acc + ACC_W'(conv_temp);
  assign busy    = (state != S_IDLE);

  always_comb begin
    state_nx      = state;
    tmr_nx        = '0;
    acc_nx        = acc;
    cnt_nx        = cnt;
    ramp_start_nx = 1'b0;
    conv_start_nx = 1'b0;
    temp_valid_nx = 1'b0;
    conv_time_nx  = conv_time;
    temp_avg_nx   = temp_avg;
    oor_nx        = oor_flag;
    tmo_nx        = timeout_flag;
    case (state)
      S_IDLE: begin
        if (enable) begin
          state_nx      = S_RAMP;
          ramp_start_nx = 1'b1;
        end
      end
      S_WAIT: begin
        if (!enable) begin
          state_nx = S_IDLE;
          acc_nx   = '0;
          cnt_nx   = '0;
        end else if (tmr == PERIOD_LAST) begin
          state_nx      = S_RAMP;
          ramp_start_nx = 1'b1;
        end else begin
          tmr_nx = tmr + 32'd1;
        end
      end
      S_RAMP: begin
        // ramp_done wins over a timeout expiring on the same cycle
        if (ramp_done) begin
          state_nx      = S_CONVERT;
          conv_time_nx  = ramp_time;
          conv_start_nx = 1'b1;
        end else if (tmr == TMO_LAST) begin
          state_nx = S_WAIT;
          tmo_nx   = 1'b1;
          acc_nx   = '0;
          cnt_nx   = '0;
        end else begin
          tmr_nx = tmr + 32'd1;
        end
      end
      S_CONVERT: begin
        if (conv_eoc) begin
          if (conv_oor) begin
            state_nx = S_WAIT;
            oor_nx   = 1'b1;
            acc_nx   = '0;
            cnt_nx   = '0;
          end else if (cnt == LAST_CNT) begin
            // result and flag clear land on the PUBLISH cycle itself
            state_nx      = S_PUBLISH;
            temp_avg_nx   = 10'(acc_sum >> AVG_LOG2);
            temp_valid_nx = 1'b1;
            oor_nx        = 1'b0;
            tmo_nx        = 1'b0;
            acc_nx        = '0;
            cnt_nx        = '0;
          end else begin
            state_nx = S_WAIT;
            acc_nx   = acc_sum;
            cnt_nx   = cnt + 1'b1;
          end
        end
      end
      S_PUBLISH: state_nx = S_WAIT;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      tmr          <= '0;
      acc          <= '0;
      cnt          <= '0;
      ramp_start   <= 1'b0;
      conv_start   <= 1'b0;
      conv_time    <= '0;
      temp_avg     <= '0;
      temp_valid   <= 1'b0;
      oor_flag     <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      state        <= state_nx;
      tmr          <= tmr_nx;
      acc          <= acc_nx;
      cnt          <= cnt_nx;
      ramp_start   <= ramp_start_nx;
      conv_start   <= conv_start_nx;
      conv_time    <= conv_time_nx;
      temp_avg     <= temp_avg_nx;
      temp_valid   <= temp_valid_nx;
      oor_flag     <= oor_nx;
      timeout_flag <= tmo_nx;
    end
  end

endmodule

// File: doc/temp_conversion_sequencer.md
TEMP_CONVERSION_SEQUENCER -- requirements
Module: temp_conversion_sequencer

Interface
REQ-001 SHALL have parameter PERIOD_CYCLES, default 1_000_000: idle cycles between the end of one sample and the next ramp_start.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1_048_575: maximum cycles spent waiting for ramp_done.
REQ-003 SHALL have parameter AVG_LOG2, default 2: each output averages 2^AVG_LOG2 samples (range 0..4).
REQ-004 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1: run periodic conversions while high.
REQ-007 SHALL have port ramp_start, output, 1: one-cycle pulse that starts a ramp measurement.
REQ-008 SHALL have port ramp_done, input, 1: one-cycle pulse; ramp_time is valid on the same cycle.
REQ-009 SHALL have port ramp_time, input, 20: down-ramp duration in clk cycles.
REQ-010 SHALL have port conv_start, output, 1: one-cycle pulse to the time-to-temperature converter.
REQ-011 SHALL have port conv_time, output, 20: registered ramp_time, held stable from conv_start until conv_eoc.
REQ-012 SHALL have ports conv_eoc, input, 1 (end of conversion), conv_temp, input, 10 (tenths of a degree C) and conv_oor, input, 1 (out of range).
REQ-013 SHALL have port temp_avg, output, 10: averaged temperature, held until the next update.
REQ-014 SHALL have port temp_valid, output, 1: one-cycle pulse when temp_avg updates.
REQ-015 SHALL have ports oor_flag, output, 1 and timeout_flag, output, 1: sticky error flags.
REQ-016 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-017 SHALL implement the states IDLE, WAIT, RAMP, CONVERT and PUBLISH.
REQ-018 IDLE: when enable=1, SHALL pulse ramp_start on the next cycle and enter RAMP.
REQ-019 RAMP: on ramp_done=1, SHALL latch ramp_time into conv_time, pulse conv_start on the following cycle and enter CONVERT.
REQ-020 RAMP: SHALL count waited cycles; when the count reaches TIMEOUT_CYCLES with no ramp_done, SHALL set timeout_flag, clear the accumulator and sample count, and enter WAIT.
REQ-021 RAMP: ramp_done on the same cycle as timeout expiry SHALL be treated as success (no timeout).
REQ-022 CONVERT: on conv_eoc=1 with conv_oor=0, SHALL add conv_temp into an accumulator of (10+AVG_LOG2) bits and increment the sample count.
REQ-023 CONVERT: on conv_eoc=1 with conv_oor=1, SHALL set oor_flag, discard the partial batch (clear accumulator and count), and enter WAIT.
REQ-024 CONVERT: CONVERT has no timeout; the converter is required to produce conv_eoc.
REQ-025 After a good sample, SHALL enter PUBLISH if the count equals 2^AVG_LOG2, otherwise enter WAIT.
REQ-026 PUBLISH: for exactly one cycle, SHALL set temp_avg = accumulator >> AVG_LOG2 (truncating), pulse temp_valid, clear oor_flag, timeout_flag, accumulator and count, then enter WAIT.
REQ-027 WAIT: SHALL count PERIOD_CYCLES cycles, then pulse ramp_start and enter RAMP.
REQ-028 WAIT: if enable=0 on any cycle, SHALL go to IDLE on the next cycle and clear the accumulator and count; flags and temp_avg SHALL be retained.
REQ-029 enable SHALL be ignored in RAMP and CONVERT; an in-flight sample always completes.
REQ-030 ramp_done outside RAMP and conv_eoc outside CONVERT SHALL be ignored.
REQ-031 At most one ramp_start and one conv_start pulse SHALL be issued per sample.

Reset
REQ-032 rst=1 SHALL force state IDLE from any state on the next edge, including mid-RAMP and mid-CONVERT.
REQ-033 rst=1 SHALL clear the counters and the accumulator.
REQ-034 rst=1 SHALL set ramp_start=0, conv_start=0, conv_time=0, temp_avg=0, temp_valid=0, oor_flag=0, timeout_flag=0 and busy=0.
REQ-035 rst SHALL take priority over every other input.

Verification
REQ-036 Scenario "average": PERIOD_CYCLES=10, AVG_LOG2=2; enable=1; converter returns 250, 251, 252, 253 -> one temp_valid pulse with temp_avg=251; exactly 4 ramp_start pulses; each ramp_start comes 10 cycles after the previous sample ends.
REQ-037 Scenario "latency": ramp_done with ramp_time=20'd600000 at cycle N -> conv_start=1 at N+1; conv_time=600000 held until conv_eoc.
REQ-038 Scenario "out of range": conv_oor=1 on the 2nd sample of a batch -> oor_flag=1, no temp_valid; the next 4 good samples of 100 produce temp_avg=100 and oor_flag=0.
REQ-039 Scenario "timeout": TIMEOUT_CYCLES=50; ramp_done withheld -> timeout_flag=1 exactly 50 cycles after ramp_start; a new ramp_start follows PERIOD_CYCLES later; ramp_done arriving on cycle 50 -> no timeout.
REQ-040 Scenario "reset and enable": rst pulsed mid-CONVERT -> all outputs 0, busy=0, and a later conv_eoc is ignored; enable dropped in WAIT -> IDLE, and temp_avg is retained.
